if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and drives it to IMEM as the read address. It captures the instruction IMEM returns combinationally into the IF/ID pipeline register. It handles stall, branch/jump redirect, halt detection and a fetched-instruction counter.

Parameters:
WIDTH, `WIDTH (32), data and address width shared with IMEM.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_INSTR, 32'hFC00_0000, instruction encoding (opcode 0x3F) that stops fetch.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard unit request to hold PC and IF/ID.
redirect  in  1  taken branch/jump resolved in ID.
redirect_pc  in  WIDTH  branch/jump target byte address.
imem_pc  out  WIDTH  read address to IMEM, equal to the PC register.
imem_instr  in  WIDTH  IMEM read data, combinational from imem_pc.
ifid_instr  out  WIDTH  IF/ID instruction.
ifid_pc  out  WIDTH  IF/ID address of ifid_instr.
ifid_pc4  out  WIDTH  IF/ID ifid_pc + 4.
ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
halted  out  1  fetch stopped on HALT_INSTR.
misalign_err  out  1  sticky flag: redirect target not word-aligned.
fetch_count  out  32  instructions delivered to IF/ID, saturating.

Behaviour:
- All state updates on the rising edge of clk. rst is sampled synchronously and overrides every other input.
- Reset values: pc=RESET_PC, state=BOOT, ifid_instr/ifid_pc/ifid_pc4=0, ifid_valid=0, halted=0, misalign_err=0, fetch_count=0.
- imem_pc = pc at all times. An instruction read at pc appears on ifid_* one clock later.
- "Bubble" means ifid_instr=0 (MIPS nop), ifid_pc=0, ifid_pc4=0, ifid_valid=0.
- State BOOT: exactly one cycle after reset. No capture and ifid_valid stays 0. stall is ignored. Next state is RUN with pc unchanged. If redirect=1 in BOOT, pc loads the aligned target, then next state is RUN.
- State RUN, per-cycle priority is redirect > stall > halt detection > advance:
  - Redirect: pc <= {redirect_pc[WIDTH-1:2], 2'b00} and IF/ID <= bubble, even when stall=1. If redirect_pc[1:0] != 0, misalign_err <= 1; it stays set until rst. fetch_count is unchanged.
  - Stall (redirect=0): pc, IF/ID and fetch_count hold.
  - Halt detection (imem_instr == HALT_INSTR): IF/ID <= bubble, pc holds, halted <= 1, state moves to HALT. fetch_count is unchanged.
  - Advance: IF/ID <= {imem_instr, pc, pc+4} with ifid_valid=1, and pc <= pc+4. fetch_count increments and saturates at 32'hFFFF_FFFF.
- State HALT: pc and IF/ID hold (bubble) and stall is ignored. redirect=1 loads the aligned target, clears halted and moves to RUN.
- Arithmetic: pc+4 is modulo 2^WIDTH, so 32'hFFFF_FFFC advances to 0. No out-of-range checking is done; address decode is IMEM's job.
- Reset mid-operation (any state, including stall or halt): the next edge applies the reset values exactly. Pending redirect and stall are discarded.

Test Plan:
- Reset, then run free with IMEM holding 0x20080005, 0x20090003, 0x01095020 at 0/4/8 -> ifid_valid=0 during BOOT. Next three cycles show ifid_pc=0,4,8 with those instrs and ifid_pc4=4,8,C. fetch_count=3.
- Assert stall for 2 cycles while pc=8 -> imem_pc stays 8 and ifid_* is frozen on pc=4. Fetch resumes at 8 with no duplicated or dropped instruction.
- redirect=1, redirect_pc=0x40, together with stall=1 at pc=0xC -> next cycle pc=0x40 and IF/ID bubble (valid=0, instr=0). The following cycle ifid_pc=0x40.
- redirect_pc=0x42 -> pc=0x40 and misalign_err=1. It stays 1 through later correct redirects and clears only on rst.
- IMEM word at 0x10 = 0xFC000000 -> halted=1, imem_pc frozen at 0x10, ifid_valid=0, fetch_count frozen. redirect to 0x0 -> halted=0 and fetch restarts at 0.
- Preload pc via redirect to 0xFFFFFFFC and advance -> ifid_pc=0xFFFFFFFC, ifid_pc4=0x0, next pc=0. Assert rst while stall=1 -> all outputs return to reset values and state is BOOT.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures IMEM data into IF/ID, and
// handles stall, redirect, halt detection and a saturating fetch counter.
module if_fetch_unit #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_PC   = '0,
  parameter logic [WIDTH-1:0]     HALT_INSTR = 32'hFC00_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] imem_pc,
  input  logic [WIDTH-1:0] imem_instr,
  output logic [WIDTH-1:0] ifid_instr,
  output logic [WIDTH-1:0] ifid_pc,
  output logic [WIDTH-1:0] ifid_pc4,
  output logic             ifid_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [31:0]      fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic [WIDTH-1:0] ipc4_q, ipc4_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             mis_q, mis_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] target;
  logic             target_mis;

  assign pc_plus4   = pc_q + WIDTH'(4);
  assign target     = {redirect_pc[WIDTH-1:2], 2'b00};
  assign target_mis = |redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      ipc4_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ipc4_q   <= ipc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    ipc4_d   = ipc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      BOOT: begin
        // IF/ID still holds the reset bubble; only the PC may be retargeted.
        state_d = RUN;
        if (redirect) begin
          pc_d  = target;
          mis_d = mis_q | target_mis;
        end
      end

      RUN: begin
        if (redirect) begin
          pc_d    = target;
          mis_d   = mis_q | target_mis;
          instr_d = '0;
          ipc_d   = '0;
          ipc4_d  = '0;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (imem_instr == HALT_INSTR) begin
          instr_d  = '0;
          ipc_d    = '0;
          ipc4_d   = '0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          instr_d = imem_instr;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end

      HALT: begin
        if (redirect) begin
          pc_d     = target;
          mis_d    = mis_q | target_mis;
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  assign imem_pc      = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc      = ipc_q;
  assign ifid_pc4     = ipc4_q;
  assign ifid_valid   = valid_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random
// stall/redirect/reset traffic against a cycle-level behavioural model.
module tb_if_fetch_unit;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_pc, imem_instr;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4, fetch_count;
  logic        ifid_valid, halted, misalign_err;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_boot, m_halt, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;

  if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc[7:2]];

  // Apply one clock of stimulus; model advances by the documented priority rules.
  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    logic [31:0] w;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    w = mem[m_pc[7:2]];
    if (r) begin
      m_boot = 1; m_halt = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
      m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (m_boot || m_halt) begin
      if (rd) begin
        m_pc = rpc & ~32'd3; m_mis = m_mis | (rpc[1:0] != 0); m_halt = 0;
      end
      m_boot = 0;
    end else if (rd) begin
      m_pc = rpc & ~32'd3; m_mis = m_mis | (rpc[1:0] != 0);
      m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
    end else if (s) begin
      // hold everything
    end else if (w == HALT) begin
      m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_valid = 0; m_halt = 1;
    end else begin
      m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 0; stall = 0; redirect = 0; redirect_pc = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = 32'h1;
    end
    mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003; mem[2] = 32'h0109_5020;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", imem_pc); end
    total++; if ({ifid_instr, ifid_pc, ifid_pc4} !== 96'h0) begin bad++; $display("FAIL reset_ifid got=%h/%h/%h exp=0", ifid_instr, ifid_pc, ifid_pc4); end
    total++; if ({ifid_valid, halted, misalign_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ifid_valid, halted, misalign_err}); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_free_run_stall();
    cycle(0, 0, 0, 0);  // BOOT
    total++; if (ifid_valid !== 1'b0 || imem_pc !== 32'h0) begin bad++; $display("FAIL boot got valid=%b pc=%h exp valid=0 pc=0", ifid_valid, imem_pc); end
    cycle(0, 0, 0, 0);
    total++; if ({ifid_instr, ifid_pc, ifid_pc4, ifid_valid} !== {32'h2008_0005, 32'h0, 32'h4, 1'b1}) begin bad++; $display("FAIL fetch0 got=%h %h %h %b", ifid_instr, ifid_pc, ifid_pc4, ifid_valid); end
    cycle(0, 0, 0, 0);
    total++; if ({ifid_instr, ifid_pc, ifid_pc4} !== {32'h2009_0003, 32'h4, 32'h8}) begin bad++; $display("FAIL fetch4 got=%h %h %h", ifid_instr, ifid_pc, ifid_pc4); end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0);
      total++; if (imem_pc !== 32'h8 || ifid_pc !== 32'h4 || ifid_instr !== 32'h2009_0003 || fetch_count !== 32'd2) begin bad++; $display("FAIL stall%0d got pc=%h ifid_pc=%h cnt=%0d exp pc=8 ifid_pc=4 cnt=2", i, imem_pc, ifid_pc, fetch_count); end
    end
    cycle(0, 0, 0, 0);
    total++; if ({ifid_instr, ifid_pc, ifid_pc4} !== {32'h0109_5020, 32'h8, 32'hC} || fetch_count !== 32'd3) begin bad++; $display("FAIL fetch8 got=%h %h %h cnt=%0d", ifid_instr, ifid_pc, ifid_pc4, fetch_count); end
  endtask

  task automatic test_redirect();
    cycle(0, 1, 1, 32'h40);  // redirect beats stall
    total++; if (imem_pc !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || fetch_count !== 32'd3) begin bad++; $display("FAIL redir got pc=%h valid=%b instr=%h cnt=%0d", imem_pc, ifid_valid, ifid_instr, fetch_count); end
    cycle(0, 0, 0, 0);
    total++; if (ifid_pc !== 32'h40 || ifid_instr !== mem[16]) begin bad++; $display("FAIL after_redir got ifid_pc=%h instr=%h exp 40 %h", ifid_pc, ifid_instr, mem[16]); end
    cycle(0, 0, 1, 32'h42);
    total++; if (imem_pc !== 32'h40 || misalign_err !== 1'b1) begin bad++; $display("FAIL misalign got pc=%h err=%b exp 40 1", imem_pc, misalign_err); end
    cycle(0, 0, 1, 32'h80);
    total++; if (imem_pc !== 32'h80 || misalign_err !== 1'b1) begin bad++; $display("FAIL sticky got pc=%h err=%b exp 80 1", imem_pc, misalign_err); end
  endtask

  task automatic test_halt();
    logic [31:0] c;
    mem[4] = HALT;
    cycle(0, 0, 1, 32'hC);
    cycle(0, 0, 0, 0);   // fetch 0xC
    c = m_cnt;
    cycle(0, 0, 0, 0);   // halt word at 0x10
    total++; if (halted !== 1'b1 || imem_pc !== 32'h10 || ifid_valid !== 1'b0 || fetch_count !== c) begin bad++; $display("FAIL halt got h=%b pc=%h v=%b cnt=%0d exp 1 10 0 %0d", halted, imem_pc, ifid_valid, fetch_count, c); end
    cycle(0, 0, 0, 0);
    total++; if (halted !== 1'b1 || imem_pc !== 32'h10 || fetch_count !== c) begin bad++; $display("FAIL halt_hold got h=%b pc=%h cnt=%0d", halted, imem_pc, fetch_count); end
    cycle(0, 0, 1, 32'h0);
    total++; if (halted !== 1'b0 || imem_pc !== 32'h0) begin bad++; $display("FAIL unhalt got h=%b pc=%h exp 0 0", halted, imem_pc); end
    cycle(0, 0, 0, 0);
    total++; if (ifid_pc !== 32'h0 || ifid_instr !== 32'h2008_0005 || ifid_valid !== 1'b1) begin bad++; $display("FAIL restart got pc=%h instr=%h v=%b", ifid_pc, ifid_instr, ifid_valid); end
    mem[4] = 32'h1;
  endtask

  task automatic test_wrap_and_reset();
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    total++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0 || imem_pc !== 32'h0) begin bad++; $display("FAIL wrap got ifid_pc=%h pc4=%h pc=%h exp FFFFFFFC 0 0", ifid_pc, ifid_pc4, imem_pc); end
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    total++; if ({imem_pc, ifid_instr, ifid_pc, ifid_pc4, fetch_count} !== 160'h0 || {ifid_valid, halted, misalign_err} !== 3'b000) begin bad++; $display("FAIL rst_mid got pc=%h cnt=%0d flags=%b", imem_pc, fetch_count, {ifid_valid, halted, misalign_err}); end
    cycle(0, 1, 0, 0);  // BOOT ignores stall
    total++; if (ifid_valid !== 1'b0 || imem_pc !== 32'h0) begin bad++; $display("FAIL boot_stall got v=%b pc=%h exp 0 0", ifid_valid, imem_pc); end
    cycle(0, 0, 0, 0);
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || fetch_count !== 32'd1) begin bad++; $display("FAIL post_boot got v=%b pc=%h cnt=%0d exp 1 0 1", ifid_valid, ifid_pc, fetch_count); end
  endtask

  task automatic test_random();
    logic r, s, rd;
    logic [31:0] t;
    for (int i = 0; i < 6; i++) mem[$urandom_range(63, 1)] = HALT;
    cycle(1, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(3) == 0);
      rd = ($urandom_range(7) == 0);
      t  = {24'h0, 6'($urandom), 2'b00};
      if (rd && $urandom_range(3) == 0 && !m_boot && !m_halt) t[1:0] = 2'($urandom);
      cycle(r, s, rd, t);
      total++;
      if ({imem_pc, ifid_instr, ifid_pc, ifid_pc4, fetch_count, ifid_valid, halted, misalign_err}
          !== {m_pc, m_instr, m_ipc, m_ipc4, m_cnt, m_valid, m_halt, m_mis}) begin
        bad++;
        $display("FAIL random n=%0d got pc=%h i=%h ipc=%h pc4=%h cnt=%0d v=%b h=%b m=%b exp pc=%h i=%h ipc=%h pc4=%h cnt=%0d v=%b h=%b m=%b",
                 n, imem_pc, ifid_instr, ifid_pc, ifid_pc4, fetch_count, ifid_valid, halted, misalign_err,
                 m_pc, m_instr, m_ipc, m_ipc4, m_cnt, m_valid, m_halt, m_mis);
      end
    end
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    m_boot = 1; m_halt = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
    m_valid = 0; m_mis = 0; m_cnt = 0;
    fill_mem();
    @(negedge clk);
    test_reset();
    test_free_run_stall();
    test_redirect();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
